// File: rtl/mul_err_pkg.sv
// Shared types and helpers for the approximate-multiplier error monitor.
package mul_err_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  // Widest product abs_diff can handle; callers zero-extend into it and truncate the result.
  localparam int ABS_W     = 64;
  localparam int SUM_W_DEF = 32;

  // Saturation value for the default accumulator width. Instances with another SUM_W derive their own.
  localparam logic [SUM_W_DEF-1:0] SUM_MAX = '1;

  function automatic logic [ABS_W-1:0] abs_diff(input logic [ABS_W-1:0] r,
                                               input logic [ABS_W-1:0] p);
    return (r >= p) ? (r - p) : (p - r);
  endfunction

endpackage

// File: rtl/mul_err_stage.sv
// Stage-2 datapath: error distance, saturating sum, error/sample counts and worst-case tracking.
module mul_err_stage
  import mul_err_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int SUM_W = 2*W+CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             vld,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  input  logic [2*W-1:0]   r,
  input  logic [2*W-1:0]   p,
  output logic [SUM_W-1:0] err_sum,
  output logic [2*W-1:0]   err_max,
  output logic [W-1:0]     worst_a,
  output logic [W-1:0]     worst_b,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] smp_cnt
);

  localparam logic [SUM_W-1:0] SAT_MAX = '1;

  logic [SUM_W-1:0] err_sum_q, err_sum_d;
  logic [2*W-1:0]   err_max_q, err_max_d;
  logic [W-1:0]     worst_a_q, worst_a_d;
  logic [W-1:0]     worst_b_q, worst_b_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [2*W-1:0]   ed;
  logic [SUM_W:0]   sum_wide;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    err_sum_d = err_sum_q;
    err_max_d = err_max_q;
    worst_a_d = worst_a_q;
    worst_b_d = worst_b_q;
    err_cnt_d = err_cnt_q;
    smp_cnt_d = smp_cnt_q;
    ed        = (2*W)'(abs_diff(ABS_W'(r), ABS_W'(p)));
    sum_wide  = {1'b0, err_sum_q} + (SUM_W+1)'(ed);
    if (clr) begin
      err_sum_d = '0;
      err_max_d = '0;
      worst_a_d = '0;
      worst_b_d = '0;
      err_cnt_d = '0;
      smp_cnt_d = '0;
    end else if (vld) begin
      err_sum_d = sum_wide[SUM_W] ? SAT_MAX : sum_wide[SUM_W-1:0];
      err_cnt_d = err_cnt_q + CNT_W'(ed != '0);
      smp_cnt_d = smp_cnt_q + CNT_W'(1);
      // Strict compare: on a tie the earliest worst-case operands are kept.
      if (ed > err_max_q) begin
        err_max_d = ed;
        worst_a_d = a;
        worst_b_d = b;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; blocking ones here would race other flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum_q <= '0;
      err_max_q <= '0;
      worst_a_q <= '0;
      worst_b_q <= '0;
      err_cnt_q <= '0;
      smp_cnt_q <= '0;
    end else begin
      err_sum_q <= err_sum_d;
      err_max_q <= err_max_d;
      worst_a_q <= worst_a_d;
      worst_b_q <= worst_b_d;
      err_cnt_q <= err_cnt_d;
      smp_cnt_q <= smp_cnt_d;
    end
  end

  assign err_sum = err_sum_q;
  assign err_max = err_max_q;
  assign worst_a = worst_a_q;
  assign worst_b = worst_b_q;
  assign err_cnt = err_cnt_q;
  assign smp_cnt = smp_cnt_q;

endmodule

// File: rtl/mul_error_monitor.sv
// Error-metric accumulator for an approximate multiplier: run-control FSM, sample counting and
// the operand/exact-product stage feeding the stage-2 accumulators.
module mul_error_monitor
  import mul_err_pkg::*;
#(
  parameter int W     = 8,
  parameter int CNT_W = 16,
  parameter int SUM_W = 2*W+CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [2*W-1:0]   in_r,
  output logic             busy,
  output logic             done,
  output logic [SUM_W-1:0] err_sum,
  output logic [2*W-1:0]   err_max,
  output logic [W-1:0]     worst_a,
  output logic [W-1:0]     worst_b,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] smp_cnt
);

  state_e           state_q;
  logic             busy_q, done_q;
  logic [CNT_W-1:0] num_q, acc_q;
  logic             s1_valid_q, s1_valid_d;
  logic [W-1:0]     s1_a_q, s1_a_d, s1_b_q, s1_b_d;
  logic [2*W-1:0]   s1_r_q, s1_r_d, s1_p_q, s1_p_d;
  logic             hs, start_ok;

  assign in_ready = (state_q == RUN) && (acc_q < num_q);
  assign hs       = in_valid & in_ready;
  assign start_ok = start && ((state_q == IDLE) || (state_q == DONE));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      num_q   <= '0;
      acc_q   <= '0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          num_q   <= num_samples;
          acc_q   <= '0;
          state_q <= (num_samples == '0) ? DONE : RUN;
          busy_q  <= (num_samples != '0);
          done_q  <= (num_samples == '0);
        end
        RUN: if (hs) begin
          acc_q <= acc_q + CNT_W'(1);
          if (acc_q + CNT_W'(1) == num_q) state_q <= DRAIN;
        end
        // Stage 1 emptying means stage 2 absorbed the final sample on that same edge.
        DRAIN: if (!s1_valid_q) begin
          state_q <= DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    s1_valid_d = hs;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_r_d     = s1_r_q;
    s1_p_d     = s1_p_q;
    if (hs) begin
      s1_a_d = in_a;
      s1_b_d = in_b;
      s1_r_d = in_r;
      s1_p_d = (2*W)'(in_a) * (2*W)'(in_b);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_r_q     <= '0;
      s1_p_q     <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_b_q     <= s1_b_d;
      s1_r_q     <= s1_r_d;
      s1_p_q     <= s1_p_d;
    end
  end

  mul_err_stage #(.W(W), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_stage (
    .clk     (clk),
    .rst     (rst),
    .clr     (start_ok),
    .vld     (s1_valid_q),
    .a       (s1_a_q),
    .b       (s1_b_q),
    .r       (s1_r_q),
    .p       (s1_p_q),
    .err_sum (err_sum),
    .err_max (err_max),
    .worst_a (worst_a),
    .worst_b (worst_b),
    .err_cnt (err_cnt),
    .smp_cnt (smp_cnt)
  );

  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_mul_error_monitor.sv
// Randomised bench for mul_error_monitor: a default instance plus a SUM_W=17 instance sharing the
// same stimulus, both checked against a plain-arithmetic reference model.
module tb_mul_error_monitor;

  localparam int W     = 8;
  localparam int CNT_W = 16;
  localparam int SUM_W = 2*W+CNT_W;
  localparam int SAT_W = 17;
  localparam int RES_W = SUM_W + 2*W + 2*W + 2*CNT_W;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_samples = '0;
  logic             in_valid = 1'b0;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic [2*W-1:0]   in_r = '0;

  logic             in_ready, busy, done;
  logic [SUM_W-1:0] err_sum;
  logic [2*W-1:0]   err_max;
  logic [W-1:0]     worst_a, worst_b;
  logic [CNT_W-1:0] err_cnt, smp_cnt;

  logic             s_in_ready, s_busy, s_done;
  logic [SAT_W-1:0] s_err_sum;
  logic [2*W-1:0]   s_err_max;
  logic [W-1:0]     s_worst_a, s_worst_b;
  logic [CNT_W-1:0] s_err_cnt, s_smp_cnt;

  mul_error_monitor #(.W(W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_r(in_r),
    .busy(busy), .done(done), .err_sum(err_sum), .err_max(err_max),
    .worst_a(worst_a), .worst_b(worst_b), .err_cnt(err_cnt), .smp_cnt(smp_cnt)
  );

  mul_error_monitor #(.W(W), .CNT_W(CNT_W), .SUM_W(SAT_W)) dut_sat (
    .clk(clk), .rst(rst), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(s_in_ready), .in_a(in_a), .in_b(in_b), .in_r(in_r),
    .busy(s_busy), .done(s_done), .err_sum(s_err_sum), .err_max(s_err_max),
    .worst_a(s_worst_a), .worst_b(s_worst_b), .err_cnt(s_err_cnt), .smp_cnt(s_smp_cnt)
  );

  always #5 clk = ~clk;

  wire [RES_W-1:0] got_res = {err_sum, err_max, worst_a, worst_b, err_cnt, smp_cnt};

  int pass_cnt  = 0;
  int total_cnt = 0;

  int sa[$];
  int sb[$];
  int sr[$];

  logic [RES_W-1:0] exp_res;
  logic [SAT_W-1:0] exp_sat_sum;

  // Reference: error metrics straight from the definitions, over the queued samples.
  task automatic model_run();
    longint sum = 0, mx = 0, p, d;
    longint sat_lim = (longint'(1) << SAT_W) - 1;
    longint def_lim = (longint'(1) << SUM_W) - 1;
    int wa = 0, wb = 0, ec = 0;
    foreach (sa[i]) begin
      p = longint'(sa[i]) * longint'(sb[i]);
      d = (sr[i] > p) ? (sr[i] - p) : (p - sr[i]);
      sum += d;
      if (d != 0) ec++;
      if (d > mx) begin
        mx = d;
        wa = sa[i];
        wb = sb[i];
      end
    end
    exp_res = {SUM_W'((sum > def_lim) ? def_lim : sum), (2*W)'(mx), W'(wa), W'(wb),
               CNT_W'(ec), CNT_W'(sa.size())};
    exp_sat_sum = SAT_W'((sum > sat_lim) ? sat_lim : sum);
  endtask

  task automatic push(input int a, input int b, input int r);
    sa.push_back(a);
    sb.push_back(b);
    sr.push_back(r);
  endtask

  task automatic push_random(input int mode);
    int a = $urandom_range(255);
    int b = $urandom_range(255);
    int r = a * b;
    if (mode == 1) begin
      r = r + $urandom_range(8) - 4;
      if (r < 0) r = 0;
      if (r > 65535) r = 65535;
    end else if (mode == 2) begin
      r = $urandom_range(65535);
    end
    push(a, b, r);
  endtask

  // Drives one full run of the queued samples; reports what it saw for the caller to judge.
  task automatic run_stream(input int gap_pct, input bit mid_start, output logic [1:0] first_flags,
                            output bit timed_out, output logic rdy_after, output int lat);
    int idx = 0;
    int cyc = 0;
    int n = sa.size();
    logic hs;
    @(negedge clk);
    start = 1'b1;
    num_samples = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    first_flags = {busy, in_ready};
    while (idx < n && cyc < 2000) begin
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_a = W'(sa[idx]);
        in_b = W'(sb[idx]);
        in_r = (2*W)'(sr[idx]);
      end
      start = mid_start && (idx == 2);
      if (start) num_samples = CNT_W'(1);
      hs = in_valid & in_ready;
      @(negedge clk);
      cyc++;
      if (hs) idx++;
    end
    in_valid = 1'b0;
    start = 1'b0;
    timed_out = (idx < n);
    rdy_after = in_ready;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    total_cnt++;
    if ({in_ready, busy, done, got_res} !== '0) $display("FAIL reset_held: got %h expected 0", {in_ready, busy, done, got_res});
    else pass_cnt++;
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({in_ready, busy, done, got_res} !== '0) $display("FAIL reset_released: got %h expected 0", {in_ready, busy, done, got_res});
    else pass_cnt++;
  endtask

  task automatic test_directed();
    logic [1:0] ff; bit to; logic ra; int lat;
    sa = {}; sb = {}; sr = {};
    push(3, 3, 8); push(255, 255, 0); push(5, 4, 20);
    model_run();
    run_stream(0, 1'b0, ff, to, ra, lat);
    total_cnt++;
    if (ff !== 2'b11) $display("FAIL directed_first_cycle: busy,in_ready=%b expected 11", ff);
    else pass_cnt++;
    total_cnt++;
    if (to || lat != 2) $display("FAIL directed_done_latency: timeout=%0d edges=%0d expected 2", to, lat);
    else pass_cnt++;
    total_cnt++;
    if (got_res !== {32'd65026, 16'd65025, 8'd255, 8'd255, 16'd2, 16'd3})
      $display("FAIL directed_literal: got %h", got_res);
    else pass_cnt++;
    total_cnt++;
    if (got_res !== exp_res || busy !== 1'b0) $display("FAIL directed_model: got %h busy=%b expected %h busy=0", got_res, busy, exp_res);
    else pass_cnt++;
  endtask

  task automatic test_ties();
    logic [1:0] ff; bit to; logic ra; int lat;
    sa = {}; sb = {}; sr = {};
    push(2, 3, 4); push(1, 4, 2);
    model_run();
    run_stream(0, 1'b0, ff, to, ra, lat);
    total_cnt++;
    if (err_max !== 16'd2 || worst_a !== 8'd2 || worst_b !== 8'd3)
      $display("FAIL ties_first_kept: max=%0d a=%0d b=%0d expected 2 2 3", err_max, worst_a, worst_b);
    else pass_cnt++;
    total_cnt++;
    if (got_res !== exp_res) $display("FAIL ties_model: got %h expected %h", got_res, exp_res);
    else pass_cnt++;
  endtask

  task automatic test_zero();
    logic seen_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    num_samples = '0;
    seen_ready = in_ready;
    @(negedge clk);
    start = 1'b0;
    seen_ready |= in_ready;
    total_cnt++;
    if (done !== 1'b1 || busy !== 1'b0 || got_res !== '0)
      $display("FAIL zero_done: done=%b busy=%b res=%h expected 1 0 0", done, busy, got_res);
    else pass_cnt++;
    @(negedge clk);
    seen_ready |= in_ready;
    total_cnt++;
    if (seen_ready !== 1'b0 || done !== 1'b1) $display("FAIL zero_no_ready: in_ready_seen=%b done=%b expected 0 1", seen_ready, done);
    else pass_cnt++;
  endtask

  task automatic test_saturation();
    logic [1:0] ff; bit to; logic ra; int lat;
    sa = {}; sb = {}; sr = {};
    repeat (3) push(255, 255, 0);
    model_run();
    run_stream(0, 1'b0, ff, to, ra, lat);
    total_cnt++;
    if (s_err_sum !== 17'd131071 || s_err_cnt !== 16'd3)
      $display("FAIL sat_literal: sum=%0d cnt=%0d expected 131071 3", s_err_sum, s_err_cnt);
    else pass_cnt++;
    total_cnt++;
    if (s_err_sum !== exp_sat_sum || got_res !== exp_res)
      $display("FAIL sat_model: sat_sum=%0d res=%h expected %0d %h", s_err_sum, got_res, exp_sat_sum, exp_res);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    logic [1:0] ff; bit to; logic ra; int lat;
    sa = {}; sb = {}; sr = {};
    repeat (5) push_random(0);
    model_run();
    run_stream(40, 1'b1, ff, to, ra, lat);
    total_cnt++;
    if (ra !== 1'b0) $display("FAIL bp_ready_after_last: in_ready=%b expected 0", ra);
    else pass_cnt++;
    total_cnt++;
    if (to || lat != 2) $display("FAIL bp_done_latency: timeout=%0d edges=%0d expected 2", to, lat);
    else pass_cnt++;
    total_cnt++;
    if (got_res !== exp_res || smp_cnt !== 16'd5)
      $display("FAIL bp_results: got %h expected %h", got_res, exp_res);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [1:0] ff; bit to; logic ra; int lat;
    for (int run = 0; run < 8; run++) begin
      sa = {}; sb = {}; sr = {};
      for (int k = 0, n = $urandom_range(12, 1); k < n; k++) push_random($urandom_range(2));
      model_run();
      run_stream(25, 1'b0, ff, to, ra, lat);
      total_cnt++;
      if (to || lat != 2 || got_res !== exp_res)
        $display("FAIL random_run%0d: timeout=%0d edges=%0d got %h expected %h", run, to, lat, got_res, exp_res);
      else pass_cnt++;
      total_cnt++;
      if (s_err_sum !== exp_sat_sum) $display("FAIL random_sat_run%0d: got %0d expected %0d", run, s_err_sum, exp_sat_sum);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid_run();
    logic [1:0] ff; bit to; logic ra; int lat;
    @(negedge clk);
    start = 1'b1;
    num_samples = CNT_W'(10);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_a = W'($urandom_range(255));
      in_b = W'($urandom_range(255));
      in_r = (2*W)'(int'(in_a) * int'(in_b) + 1 + $urandom_range(50));
      @(negedge clk);
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if ({in_ready, busy, done, got_res} !== '0) $display("FAIL midrun_async_reset: got %h expected 0", {in_ready, busy, done, got_res});
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({in_ready, busy, done, got_res} !== '0) $display("FAIL midrun_idle: got %h expected 0", {in_ready, busy, done, got_res});
    else pass_cnt++;
    sa = {}; sb = {}; sr = {};
    repeat (2) push_random(1);
    model_run();
    run_stream(0, 1'b0, ff, to, ra, lat);
    total_cnt++;
    if (to || lat != 2 || got_res !== exp_res)
      $display("FAIL midrun_restart: timeout=%0d edges=%0d got %h expected %h", to, lat, got_res, exp_res);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ties();
    test_zero();
    test_saturation();
    test_backpressure();
    test_random();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mul_error_monitor.md
# mul_error_monitor

Streaming error-metric accumulator placed directly downstream of an unsigned approximate multiplier, such as a rounding-based approximate multiplier (8×8 → 16). Each sample carries the operand pair and the approximate product. The block computes the exact product internally and accumulates error metrics over a programmed number of samples:

- error-distance sum
- maximum error distance and the operands that produced it
- count of erroneous samples

The host derives MED and ER from these metrics in characterisation benches and on-chip self-test.

## Interface

Reset is asynchronous and active-high.

Parameters:

- `W`, default 8: operand width. Products are `2W` bits.
- `CNT_W`, default 16: width of the sample counter and error counter.
- `SUM_W`, default `2*W+CNT_W`: width of the error-distance accumulator.

Ports:

- `clk`, in, 1: the only clock.
- `rst`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: pulse that begins a run. Honoured only in IDLE or DONE.
- `num_samples`, in, `CNT_W`: number of samples to accept. Sampled on `start`.
- `in_valid`, in, 1: sample valid.
- `in_ready`, out, 1: block accepts a sample.
- `in_a`, in, `W`: operand A.
- `in_b`, in, `W`: operand B.
- `in_r`, in, `2W`: approximate product under test.
- `busy`, out, 1: high in RUN or DRAIN.
- `done`, out, 1: high in DONE. Results are stable while it is high.
- `err_sum`, out, `SUM_W`: sum of |`in_r` − A·B|. Saturating.
- `err_max`, out, `2W`: largest error distance.
- `worst_a`, out, `W`: operand A of the first sample reaching `err_max`.
- `worst_b`, out, `W`: operand B of that sample.
- `err_cnt`, out, `CNT_W`: number of samples with nonzero error distance.
- `smp_cnt`, out, `CNT_W`: number of samples accumulated.

## Operation

- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE/DONE with `start`:
  - Clear all accumulators and the stage valids, and latch `num_samples`.
  - If `num_samples` = 0, go to DONE. Otherwise go to RUN.
  - `start` in RUN or DRAIN is ignored.
- RUN:
  - `in_ready` = 1 while the accepted count < latched `num_samples`.
  - A handshake is `in_valid & in_ready`.
  - Go to DRAIN on the edge that accepts the last sample.
- DRAIN:
  - `in_ready` = 0.
  - Go to DONE on the edge where both pipeline stages are empty after the final accumulation.
- DONE: outputs hold until the next `start` or `rst`.
- Stage 1, registered on handshake: A, B, `in_r`, and the exact product A·B (full `2W`, no truncation).
- Stage 2, registered from stage 1:
  - ed = |r − p|, computed as an unsigned `2W+1`-bit difference, then its magnitude.
  - `err_sum` += ed, saturating at all-ones `SUM_W`.
  - `err_cnt` += (ed ≠ 0).
  - `smp_cnt` += 1.
  - Max update uses a strict `>` comparison, so ties keep the earliest sample. The `worst_a`/`worst_b` pair is updated together with `err_max`.
- Reset, asynchronous: state IDLE. All of the following are 0: `in_ready`, `busy`, `done`, `err_sum`, `err_max`, `worst_a`, `worst_b`, `err_cnt`, `smp_cnt`, and the stage valids.
- A reset during RUN or DRAIN aborts the run. No partial results are preserved.

## Timing

- All outputs are registered except `in_ready`, which is decoded combinationally from state and count. It does not depend on `in_valid`.
- Handshake at edge e: stage 1 loads at e, accumulators update at e+1.
- `done` rises on edge e+2 after the final handshake edge e.
- `busy` falls on that same edge.
- Throughput: one sample per cycle with no bubbles.
- `in_valid` low during RUN inserts bubbles. Bubbles do not affect the results.
- `start` to first possible handshake: `in_ready` is high in the cycle after the `start` edge.

## Structure

Shared package `mul_err_pkg`:

- state enum `{IDLE, RUN, DRAIN, DONE}`
- function `abs_diff(r, p)`
- saturation constant `SUM_MAX` per `SUM_W`

One natural sub-module, `mul_err_stage`: the stage-2 datapath, covering the ed computation, saturating add, and max/worst tracking. The top level holds the FSM, counters, and stage 1.

## Test plan

- Reset mid-RUN, after 3 of 10 samples: all outputs are 0 and the state is IDLE. A new `start` with `num_samples`=2 completes normally.
- `num_samples`=3, with samples (3,3,r=8), (255,255,r=0), (5,4,r=20) streamed with no bubbles:
  - `err_sum`=65026, `err_max`=65025, `worst_a`=255, `worst_b`=255, `err_cnt`=2, `smp_cnt`=3.
  - `done` is asserted 2 edges after the third handshake.
- Ties: samples (2,3,r=4) then (1,4,r=2), both ed=2. The result is `err_max`=2 with `worst_a`=2, `worst_b`=3 (first occurrence retained).
- `num_samples`=0 with `start`: DONE on the next edge, all results 0, `in_ready` never asserted.
- Saturation: `SUM_W` overridden to 17, `num_samples`=3, each sample (255,255,r=0). `err_sum`=131071 (saturated), `err_cnt`=3.
- Backpressure and control:
  - Random `in_valid` gaps over 5 exact samples: all metrics 0, `smp_cnt`=5.
  - `start` pulsed during RUN is ignored.
  - `in_ready`=0 after the 5th handshake.
